// File: rtl/clock_select_ctrl_if.sv
// Request handshake into the clock-select sequencer: a binary clock index
// carried with valid/ready. The master drives req_valid and req_sel; the
// slave (the sequencer) returns req_ready. A request is taken when
// req_valid & req_ready are both high at a clock edge.
interface clock_select_ctrl_if #(
    parameter int SEL_W = 2
);
    logic             req_valid;
    logic [SEL_W-1:0] req_sel;
    logic             req_ready;

    modport master (
        output req_valid,
        output req_sel,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_sel,
        output req_ready
    );
endinterface

// File: rtl/clock_select_ctrl.sv
// Sequencer that drives the one-hot select of a downstream glitch-free clock mux.
// Latency: a switch shows all-zero select for OFF_CYCLES cycles, then the new select
//   for ON_CYCLES cycles, then a one-cycle done pulse; same-index or bad-index requests answer next cycle.
// Backpressure: req_ready is low while a switch or the post-reset settle runs; a held request is taken on the first idle cycle.
//
// Ports: clk, reset_n (async active-low); req (request handshake, slave side);
//   clk_select (one-hot or zero), cur_sel, busy, done, err.
// Optional: define CLOCK_SELECT_CTRL_STATS_EN to add the switch_count output,
//   a saturating count of completed real switches.
module clock_select_ctrl #(
    parameter int NUM_CLOCKS  = 3,
    parameter int SEL_W       = 2,
    parameter int DEFAULT_SEL = 0,
    parameter int OFF_CYCLES  = 8,
    parameter int ON_CYCLES   = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    clock_select_ctrl_if.slave    req,
    output logic [NUM_CLOCKS-1:0] clk_select,
    output logic [SEL_W-1:0]      cur_sel,
    output logic                  busy,
    output logic                  done,
    output logic                  err
`ifdef CLOCK_SELECT_CTRL_STATS_EN
    ,
    output logic [15:0]           switch_count
`endif
);

    localparam logic [1:0] ST_INIT     = 2'd0;
    localparam logic [1:0] ST_IDLE     = 2'd1;
    localparam logic [1:0] ST_DESELECT = 2'd2;
    localparam logic [1:0] ST_SETTLE   = 2'd3;

    localparam logic [7:0]            OFF_M1      = 8'(OFF_CYCLES - 1);
    localparam logic [7:0]            ON_M1       = 8'(ON_CYCLES - 1);
    localparam logic [SEL_W-1:0]      DEF_IDX     = SEL_W'(DEFAULT_SEL);
    localparam logic [NUM_CLOCKS-1:0] DEF_ONEHOT  = NUM_CLOCKS'(1) << DEFAULT_SEL;
    // One extra bit so the range check works even when 2**SEL_W == NUM_CLOCKS.
    localparam logic [SEL_W:0]        NUM_CLK_EXT = (SEL_W+1)'(NUM_CLOCKS);

    logic [1:0]       state;
    logic [7:0]       cnt;
    logic [SEL_W-1:0] target;

    function automatic logic [NUM_CLOCKS-1:0] onehot(input logic [SEL_W-1:0] idx);
        logic [NUM_CLOCKS-1:0] r;
        r = '0;
        for (int i = 0; i < NUM_CLOCKS; i++) begin
            if (idx == SEL_W'(i)) r[i] = 1'b1;
        end
        return r;
    endfunction

    logic accept;
    assign accept = req.req_valid && req.req_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= ST_INIT;
            cnt           <= 8'd0;
            target        <= DEF_IDX;
            clk_select    <= DEF_ONEHOT;
            cur_sel       <= DEF_IDX;
            busy          <= 1'b1;
            req.req_ready <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                // The counter resets to 0, so the post-reset settle counts up
                // to ON_CYCLES-1 instead of down from it.
                ST_INIT: begin
                    if (cnt == ON_M1) begin
                        state         <= ST_IDLE;
                        cnt           <= 8'd0;
                        busy          <= 1'b0;
                        req.req_ready <= 1'b1;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                ST_IDLE: begin
                    if (accept) begin
                        if ({1'b0, req.req_sel} >= NUM_CLK_EXT) begin
                            err <= 1'b1;
                        end else if (req.req_sel == cur_sel) begin
                            done <= 1'b1;
                        end else begin
                            target        <= req.req_sel;
                            state         <= ST_DESELECT;
                            cnt           <= OFF_M1;
                            clk_select    <= '0;
                            busy          <= 1'b1;
                            req.req_ready <= 1'b0;
                        end
                    end
                end
                ST_DESELECT: begin
                    if (cnt == 8'd0) begin
                        state      <= ST_SETTLE;
                        cnt        <= ON_M1;
                        clk_select <= onehot(target);
                        cur_sel    <= target;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                ST_SETTLE: begin
                    if (cnt == 8'd0) begin
                        state         <= ST_IDLE;
                        busy          <= 1'b0;
                        req.req_ready <= 1'b1;
                        done          <= 1'b1;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                default: begin
                    state         <= ST_INIT;
                    cnt           <= 8'd0;
                    target        <= DEF_IDX;
                    clk_select    <= DEF_ONEHOT;
                    cur_sel       <= DEF_IDX;
                    busy          <= 1'b1;
                    req.req_ready <= 1'b0;
                end
            endcase
        end
    end

`ifdef CLOCK_SELECT_CTRL_STATS_EN
    // Only the end of a real deselect/settle sequence counts as a switch.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            switch_count <= 16'd0;
        end else if (state == ST_SETTLE && cnt == 8'd0 && switch_count != 16'hFFFF) begin
            switch_count <= switch_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_clock_select_ctrl.sv
// Directed bench for clock_select_ctrl with NUM_CLOCKS=3, DEFAULT_SEL=0,
// OFF_CYCLES=4, ON_CYCLES=4. Inputs change 1 ns after a rising edge and
// outputs are sampled there; a negedge monitor checks the select invariants.
module tb_clock_select_ctrl;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [2:0] clk_select;
    logic [1:0] cur_sel;
    logic       busy;
    logic       done;
    logic       err;
`ifdef CLOCK_SELECT_CTRL_STATS_EN
    logic [15:0] switch_count;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    clock_select_ctrl_if #(.SEL_W(2)) req_if ();

    clock_select_ctrl #(
        .NUM_CLOCKS (3),
        .SEL_W      (2),
        .DEFAULT_SEL(0),
        .OFF_CYCLES (4),
        .ON_CYCLES  (4)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req       (req_if.slave),
        .clk_select(clk_select),
        .cur_sel   (cur_sel),
        .busy      (busy),
        .done      (done),
        .err       (err)
`ifdef CLOCK_SELECT_CTRL_STATS_EN
        ,
        .switch_count(switch_count)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Select invariants, checked every cycle outside reset.
    logic [2:0] prev_sel = 3'b001;
    always @(negedge clk) begin
        if (reset_n) begin
            check("sel_onehot_or_zero", 32'($countones(clk_select) <= 1), 32'd1);
            check("sel_no_direct_change",
                  32'(!(prev_sel != 3'b000 && clk_select != 3'b000 && prev_sel != clk_select)), 32'd1);
        end
        prev_sel = clk_select;
    end

    task automatic check_init_settle(input string tag);
        for (int i = 0; i < 3; i++) begin
            cyc();
            check({tag, "_busy"}, 32'(busy), 32'd1);
            check({tag, "_sel"}, 32'(clk_select), 32'b001);
            check({tag, "_done"}, 32'(done), 32'd0);
        end
        cyc();
        check({tag, "_idle_busy"}, 32'(busy), 32'd0);
        check({tag, "_idle_ready"}, 32'(req_if.req_ready), 32'd1);
        check({tag, "_idle_done"}, 32'(done), 32'd0);
        check({tag, "_idle_sel"}, 32'(clk_select), 32'b001);
    endtask

    initial begin
        req_if.req_valid = 1'b0;
        req_if.req_sel   = 2'd0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_sel", 32'(clk_select), 32'b001);
        check("rst_cur", 32'(cur_sel), 32'd0);
        check("rst_busy", 32'(busy), 32'd1);
        check("rst_ready", 32'(req_if.req_ready), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);

        reset_n = 1'b1;
        check_init_settle("init");

        // Switch 0 -> 2, accepted in cycle T
        req_if.req_valid = 1'b1;
        req_if.req_sel   = 2'd2;
        cyc();                                  // T+1
        req_if.req_valid = 1'b0;
        req_if.req_sel   = 2'd1;                // ignored after acceptance
        check("sw_t1_sel", 32'(clk_select), 32'b000);
        check("sw_t1_busy", 32'(busy), 32'd1);
        check("sw_t1_ready", 32'(req_if.req_ready), 32'd0);
        check("sw_t1_cur", 32'(cur_sel), 32'd0);
        for (int i = 2; i <= 4; i++) begin
            cyc();
            check("sw_off_sel", 32'(clk_select), 32'b000);
            check("sw_off_done", 32'(done), 32'd0);
        end
        for (int i = 5; i <= 8; i++) begin
            cyc();
            check("sw_on_sel", 32'(clk_select), 32'b100);
            check("sw_on_cur", 32'(cur_sel), 32'd2);
            check("sw_on_busy", 32'(busy), 32'd1);
            check("sw_on_done", 32'(done), 32'd0);
        end
        cyc();                                  // T+9
        check("sw_t9_done", 32'(done), 32'd1);
        check("sw_t9_busy", 32'(busy), 32'd0);
        check("sw_t9_ready", 32'(req_if.req_ready), 32'd1);
        check("sw_t9_sel", 32'(clk_select), 32'b100);
        cyc();
        check("sw_t10_done", 32'(done), 32'd0);
`ifdef CLOCK_SELECT_CTRL_STATS_EN
        check("sw_count1", 32'(switch_count), 32'd1);
`endif

        // Same-index request
        req_if.req_valid = 1'b1;
        req_if.req_sel   = 2'd2;
        cyc();
        req_if.req_valid = 1'b0;
        check("same_done", 32'(done), 32'd1);
        check("same_err", 32'(err), 32'd0);
        check("same_sel", 32'(clk_select), 32'b100);
        check("same_busy", 32'(busy), 32'd0);
        cyc();
        check("same_done_clr", 32'(done), 32'd0);
        check("same_sel2", 32'(clk_select), 32'b100);
`ifdef CLOCK_SELECT_CTRL_STATS_EN
        check("same_count", 32'(switch_count), 32'd1);
`endif

        // Out-of-range index
        req_if.req_valid = 1'b1;
        req_if.req_sel   = 2'd3;
        cyc();
        req_if.req_valid = 1'b0;
        check("bad_err", 32'(err), 32'd1);
        check("bad_done", 32'(done), 32'd0);
        check("bad_sel", 32'(clk_select), 32'b100);
        check("bad_cur", 32'(cur_sel), 32'd2);
        check("bad_ready", 32'(req_if.req_ready), 32'd1);
        cyc();
        check("bad_err_clr", 32'(err), 32'd0);
        check("bad_sel2", 32'(clk_select), 32'b100);

        // Held valid with toggling req_sel: switch to 1, then back-to-back to 2
        req_if.req_valid = 1'b1;
        req_if.req_sel   = 2'd1;
        for (int k = 1; k <= 8; k++) begin
            cyc();
            req_if.req_sel = (k % 2 == 1) ? 2'd2 : 2'd1;
            check("hold_ready", 32'(req_if.req_ready), 32'd0);
            check("hold_busy", 32'(busy), 32'd1);
            if (k >= 5) check("hold_sel_on", 32'(clk_select), 32'b010);
            else        check("hold_sel_off", 32'(clk_select), 32'b000);
        end
        cyc();                                  // done cycle
        req_if.req_sel = 2'd2;
        check("hold_done", 32'(done), 32'd1);
        check("hold_ready_done", 32'(req_if.req_ready), 32'd1);
        check("hold_cur", 32'(cur_sel), 32'd1);
        cyc();                                  // second request taken in the done cycle
        req_if.req_valid = 1'b0;
        check("b2b_sel", 32'(clk_select), 32'b000);
        check("b2b_busy", 32'(busy), 32'd1);
        check("b2b_done", 32'(done), 32'd0);
        repeat (8) cyc();
        check("b2b_final_done", 32'(done), 32'd1);
        check("b2b_final_sel", 32'(clk_select), 32'b100);
        check("b2b_final_cur", 32'(cur_sel), 32'd2);
`ifdef CLOCK_SELECT_CTRL_STATS_EN
        check("b2b_count", 32'(switch_count), 32'd3);
`endif

        // Reset during DESELECT
        req_if.req_valid = 1'b1;
        req_if.req_sel   = 2'd0;
        cyc();
        req_if.req_valid = 1'b0;
        check("mid_pre_sel", 32'(clk_select), 32'b000);
        cyc();
        #2;
        reset_n = 1'b0;
        #1;
        check("mid_rst_sel", 32'(clk_select), 32'b001);
        check("mid_rst_busy", 32'(busy), 32'd1);
        check("mid_rst_ready", 32'(req_if.req_ready), 32'd0);
        check("mid_rst_cur", 32'(cur_sel), 32'd0);
`ifdef CLOCK_SELECT_CTRL_STATS_EN
        check("mid_rst_count", 32'(switch_count), 32'd0);
`endif
        cyc();
        reset_n = 1'b1;
        check_init_settle("reinit");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
